// File: rtl/exec_core_pkg.sv
// Shared widths, state encoding and line layout for the execution core.
package exec_core_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int BUS_WIDTH_DEF    = 8;
  localparam int IP_WIDTH_DEF     = 8;
  localparam int OPCODE_WIDTH_DEF = 7;
  localparam int CNT_WIDTH_DEF    = 16;

  // Line fields, counted in BUS_WIDTH slots from the LSB: {instr_idx, dest, src1, src2}
  localparam int FIELD_IDX  = 3;
  localparam int FIELD_DEST = 2;
  localparam int FIELD_SRC1 = 1;
  localparam int FIELD_SRC2 = 0;

  localparam logic [OPCODE_WIDTH_DEF-1:0] HALT_OPCODE = '1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_OPC,
    ST_RD1,
    ST_WT1,
    ST_RD2,
    ST_WT2,
    ST_EXEC,
    ST_WB,
    ST_NEXT,
    ST_HALT
  } exec_state_e;

endpackage

// File: rtl/exec_core_ram_req_port.sv
// Hold-until-accepted RAM request with optional tracking of the returning read valid.
module ram_req_port #(
  parameter bit TRACK_VALID = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic busy_in,
  input  logic valid_in,
  output logic req,
  output logic accept,
  output logic done
);

  logic req_q, req_d;
  logic wait_q, wait_d;

  assign req    = req_q;
  assign accept = req_q & ~busy_in;
  assign done   = TRACK_VALID ? (wait_q & valid_in) : accept;

  always_comb begin
    req_d  = (req_q & busy_in) | start;
    wait_d = wait_q;
    if (accept) begin
      wait_d = TRACK_VALID;
    end else if (wait_q & valid_in) begin
      wait_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q  <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/exec_core.sv
// Self-sequencing execution core: fetch, decode, two operand reads, ALU, write-back
// and instruction-pointer update, with run/step control, halt and a retired counter.
module exec_core
  import exec_core_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int BUS_WIDTH    = BUS_WIDTH_DEF,
  parameter int IP_WIDTH     = IP_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    run,
  input  logic                    step,
  output logic                    line_mem_en,
  output logic [IP_WIDTH-1:0]     ip,
  input  logic [4*BUS_WIDTH-1:0]  line,
  output logic                    instr_mem_en,
  output logic [BUS_WIDTH-1:0]    instr_addr,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    ram_rd_en,
  output logic                    ram_wr_en,
  input  logic                    ram_busy,
  input  logic                    ram_rd_valid,
  input  logic [DATA_WIDTH-1:0]   data_rd,
  output logic [BUS_WIDTH-1:0]    addr_rd,
  output logic [BUS_WIDTH-1:0]    addr_wr,
  output logic [DATA_WIDTH-1:0]   data_wr,
  output logic [OPCODE_WIDTH-1:0] alu_op,
  output logic [DATA_WIDTH-1:0]   value1,
  output logic [DATA_WIDTH-1:0]   value2,
  input  logic [DATA_WIDTH-1:0]   result,
  input  logic                    update_ip,
  output logic                    alu_en,
  output logic                    ip_update_en,
  output logic                    halted,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    retired
);

  localparam int LINE_WIDTH = 4 * BUS_WIDTH;
  localparam int OP_MSB     = OPCODE_WIDTH - 1;

  exec_state_e state_q, state_d;

  logic [LINE_WIDTH-1:0]   line_q, line_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0]   value1_q, value1_d;
  logic [DATA_WIDTH-1:0]   value2_q, value2_d;
  logic [DATA_WIDTH-1:0]   data_wr_q, data_wr_d;
  logic [BUS_WIDTH-1:0]    addr_rd_q, addr_rd_d;
  logic [BUS_WIDTH-1:0]    addr_wr_q, addr_wr_d;
  logic [IP_WIDTH-1:0]     ip_q, ip_d;
  logic [CNT_WIDTH-1:0]    retired_q, retired_d;
  logic                    take_br_q, take_br_d;

  logic [BUS_WIDTH-1:0] dest_f, src1_f, src2_f;
  logic                 opc_is_halt;
  logic                 rd_start, rd_accept, rd_done;
  logic                 wr_start, wr_accept, wr_done_unused;

  assign dest_f      = line_q[FIELD_DEST*BUS_WIDTH +: BUS_WIDTH];
  assign src1_f      = line_q[FIELD_SRC1*BUS_WIDTH +: BUS_WIDTH];
  assign src2_f      = line_q[FIELD_SRC2*BUS_WIDTH +: BUS_WIDTH];
  assign opc_is_halt = &opcode;

  // One read port serves both operands; the second read is issued as the first returns.
  assign rd_start = ((state_q == ST_OPC) && !opc_is_halt) || ((state_q == ST_WT1) && rd_done);
  assign wr_start = (state_q == ST_EXEC) && !opcode_q[OP_MSB];

  ram_req_port #(.TRACK_VALID(1'b1)) u_rd_port (
    .clk      (clk),
    .rstn     (rstn),
    .start    (rd_start),
    .busy_in  (ram_busy),
    .valid_in (ram_rd_valid),
    .req      (ram_rd_en),
    .accept   (rd_accept),
    .done     (rd_done)
  );

  ram_req_port #(.TRACK_VALID(1'b0)) u_wr_port (
    .clk      (clk),
    .rstn     (rstn),
    .start    (wr_start),
    .busy_in  (ram_busy),
    .valid_in (1'b0),
    .req      (ram_wr_en),
    .accept   (wr_accept),
    .done     (wr_done_unused)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run || step) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_OPC;
      ST_OPC:    state_d = opc_is_halt ? ST_HALT : ST_RD1;
      ST_RD1:    if (rd_accept) state_d = ST_WT1;
      ST_WT1:    if (rd_done) state_d = ST_RD2;
      ST_RD2:    if (rd_accept) state_d = ST_WT2;
      ST_WT2:    if (rd_done) state_d = ST_EXEC;
      ST_EXEC:   state_d = opcode_q[OP_MSB] ? ST_NEXT : ST_WB;
      ST_WB:     if (wr_accept) state_d = ST_NEXT;
      ST_NEXT:   state_d = run ? ST_FETCH : ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    line_d    = line_q;
    opcode_d  = opcode_q;
    value1_d  = value1_q;
    value2_d  = value2_q;
    data_wr_d = data_wr_q;
    addr_rd_d = addr_rd_q;
    addr_wr_d = addr_wr_q;
    ip_d      = ip_q;
    retired_d = retired_q;
    take_br_d = take_br_q;
    case (state_q)
      ST_DECODE: line_d = line;
      ST_OPC: begin
        opcode_d  = opcode;
        addr_rd_d = src1_f;
      end
      ST_WT1: begin
        if (rd_done) begin
          value1_d  = data_rd;
          addr_rd_d = src2_f;
        end
      end
      ST_WT2: if (rd_done) value2_d = data_rd;
      ST_EXEC: begin
        data_wr_d = result;
        addr_wr_d = dest_f;
        take_br_d = opcode_q[OP_MSB] & update_ip;
      end
      ST_NEXT: begin
        ip_d = take_br_q ? IP_WIDTH'(dest_f) : ip_q + IP_WIDTH'(1);
        if (!(&retired_q)) retired_d = retired_q + CNT_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      line_q    <= '0;
      opcode_q  <= '0;
      value1_q  <= '0;
      value2_q  <= '0;
      data_wr_q <= '0;
      addr_rd_q <= '0;
      addr_wr_q <= '0;
      ip_q      <= '0;
      retired_q <= '0;
      take_br_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      opcode_q  <= opcode_d;
      value1_q  <= value1_d;
      value2_q  <= value2_d;
      data_wr_q <= data_wr_d;
      addr_rd_q <= addr_rd_d;
      addr_wr_q <= addr_wr_d;
      ip_q      <= ip_d;
      retired_q <= retired_d;
      take_br_q <= take_br_d;
    end
  end

  assign line_mem_en  = (state_q == ST_FETCH);
  assign instr_mem_en = (state_q == ST_DECODE);
  assign alu_en       = (state_q == ST_EXEC);
  assign ip_update_en = (state_q == ST_NEXT);
  assign halted       = (state_q == ST_HALT);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign ip           = ip_q;
  assign instr_addr   = line_q[FIELD_IDX*BUS_WIDTH +: BUS_WIDTH];
  assign addr_rd      = addr_rd_q;
  assign addr_wr      = addr_wr_q;
  assign data_wr      = data_wr_q;
  assign alu_op       = opcode_q;
  assign value1       = value1_q;
  assign value2       = value2_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_exec_core.sv
// Scoreboarded bench for exec_core: RAM writes and IP updates are checked against queued expectations.
module tb_exec_core;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        line_mem_en, instr_mem_en, ram_rd_en, ram_wr_en;
  logic        ram_busy = 1'b0;
  logic        ram_rd_valid = 1'b0;
  logic [7:0]  data_rd = 8'h00;
  logic [7:0]  ip, instr_addr, addr_rd, addr_wr, data_wr, value1, value2, result;
  logic [31:0] line;
  logic [6:0]  opcode, alu_op;
  logic        update_ip, alu_en, ip_update_en, halted, busy;
  logic [15:0] retired;
  logic        br_flag = 1'b0;

  logic [31:0] lmem [256];
  logic [6:0]  imem [256];
  logic [7:0]  ram  [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign line      = lmem[ip];
  assign opcode    = imem[instr_addr];
  assign update_ip = br_flag;

  always_comb begin
    case (alu_op)
      7'h01:   result = value1 + value2;
      7'h02:   result = value1 - value2;
      default: result = value1 ^ value2;
    endcase
  end

  exec_core dut (
    .clk(clk), .rstn(rstn), .run(run), .step(step),
    .line_mem_en(line_mem_en), .ip(ip), .line(line),
    .instr_mem_en(instr_mem_en), .instr_addr(instr_addr), .opcode(opcode),
    .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_busy(ram_busy),
    .ram_rd_valid(ram_rd_valid), .data_rd(data_rd),
    .addr_rd(addr_rd), .addr_wr(addr_wr), .data_wr(data_wr),
    .alu_op(alu_op), .value1(value1), .value2(value2), .result(result),
    .update_ip(update_ip), .alu_en(alu_en), .ip_update_en(ip_update_en),
    .halted(halted), .busy(busy), .retired(retired)
  );

  // Small second core with a 2-bit counter so saturation is reachable quickly.
  logic        sat_run = 1'b0;
  logic        s_line_en, s_instr_en, s_rd_en, s_wr_en, s_alu_en, s_ipu, s_halted, s_busy;
  logic [7:0]  s_ip, s_instr_addr, s_addr_rd, s_addr_wr, s_data_wr, s_v1, s_v2;
  logic [6:0]  s_alu_op;
  logic [1:0]  s_retired;
  logic        s_valid = 1'b0;

  always @(posedge clk) s_valid <= s_rd_en;

  exec_core #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rstn(rstn), .run(sat_run), .step(1'b0),
    .line_mem_en(s_line_en), .ip(s_ip), .line(32'h0000_0000),
    .instr_mem_en(s_instr_en), .instr_addr(s_instr_addr), .opcode(7'h40),
    .ram_rd_en(s_rd_en), .ram_wr_en(s_wr_en), .ram_busy(1'b0),
    .ram_rd_valid(s_valid), .data_rd(8'h00),
    .addr_rd(s_addr_rd), .addr_wr(s_addr_wr), .data_wr(s_data_wr),
    .alu_op(s_alu_op), .value1(s_v1), .value2(s_v2), .result(8'h00),
    .update_ip(1'b0), .alu_en(s_alu_en), .ip_update_en(s_ipu),
    .halted(s_halted), .busy(s_busy), .retired(s_retired)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_q [$];
  logic [7:0] ip_q [$];

  int         busy_left = 0;
  int         lat_next = 1;
  int         rd_cnt = 0;
  logic [7:0] rd_hold = 8'h00;
  logic       prev_wait_rd = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  int         hold_err = 0;
  int         fetch_cnt = 0;
  logic       ipu_prev = 1'b0;
  int         exp_ret = 0;

  // RAM model: decides busy/valid on the falling edge for the next rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      rd_cnt = 0;
      ram_rd_valid = 1'b0;
      ram_busy = 1'b0;
      prev_wait_rd = 1'b0;
    end else begin
      ram_rd_valid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          ram_rd_valid = 1'b1;
          data_rd = rd_hold;
        end
      end
      if (prev_wait_rd && (!ram_rd_en || addr_rd != prev_addr)) hold_err++;
      if ((ram_rd_en || ram_wr_en) && busy_left > 0) begin
        ram_busy = 1'b1;
        busy_left--;
      end else begin
        ram_busy = 1'b0;
      end
      prev_wait_rd = ram_rd_en && ram_busy;
      prev_addr = addr_rd;
      if (ram_rd_en && !ram_busy) begin
        rd_hold = ram[addr_rd];
        rd_cnt = lat_next;
        lat_next = 1;
      end
      if (ram_wr_en && !ram_busy) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got addr=%h data=%h required no write", addr_wr, data_wr);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          if (addr_wr !== e.a || data_wr !== e.d) begin
            failures++;
            $display("FAIL write got addr=%h data=%h required addr=%h data=%h", addr_wr, data_wr, e.a, e.d);
          end
        end
        ram[addr_wr] = data_wr;
      end
    end
  end

  // IP scoreboard: checked one cycle after each NEXT.
  always @(negedge clk) begin
    if (ipu_prev) begin
      checks++;
      if (ip_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ip_update got ip=%h", ip);
      end else begin
        logic [7:0] e;
        e = ip_q.pop_front();
        if (ip !== e) begin
          failures++;
          $display("FAIL ip_update got=%h required=%h", ip, e);
        end
      end
    end
    ipu_prev = ip_update_en && rstn;
    if (line_mem_en) fetch_cnt++;
  end

  task automatic run_one(input bit use_step, output int cyc);
    int guard;
    cyc = 0;
    @(negedge clk);
    if (use_step) step = 1'b1;
    else run = 1'b1;
    @(negedge clk);
    step = 1'b0;
    guard = 0;
    while (!line_mem_en && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cyc = 1;
    while (!ip_update_en && guard < 200) begin
      @(negedge clk);
      cyc++;
      guard++;
    end
    run = 1'b0;
    checks++;
    if (guard >= 200 || !ip_update_en) begin
      failures++;
      $display("FAIL instr_timeout got cycles=%0d required completion", cyc);
    end
    exp_ret++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ip !== 8'h00) begin failures++; $display("FAIL reset_ip got=%h required=00", ip); end
    checks++;
    if (retired !== 16'h0000) begin failures++; $display("FAIL reset_retired got=%h required=0000", retired); end
    checks++;
    if ({busy, halted} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b required=00", {busy, halted}); end
    checks++;
    if ({line_mem_en, instr_mem_en, ram_rd_en, ram_wr_en, alu_en, ip_update_en} !== 6'b0) begin
      failures++;
      $display("FAIL reset_enables got=%b required=000000",
               {line_mem_en, instr_mem_en, ram_rd_en, ram_wr_en, alu_en, ip_update_en});
    end
    rstn = 1'b1;
    @(negedge clk);
    $display("reset: ip=%h retired=%h", ip, retired);
  endtask

  task automatic test_add();
    int cyc;
    wr_q.push_back('{a: 8'h10, d: 8'h07});
    ip_q.push_back(8'h01);
    run_one(1'b0, cyc);
    checks++;
    if (cyc !== 10) begin failures++; $display("FAIL add_cycles got=%0d required=10", cyc); end
    checks++;
    if (ram[8'h10] !== 8'h07) begin failures++; $display("FAIL add_ram got=%h required=07", ram[8'h10]); end
    checks++;
    if (retired !== 16'(exp_ret)) begin failures++; $display("FAIL add_retired got=%0d required=%0d", retired, exp_ret); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL add_idle got busy=%b required=0", busy); end
    $display("add: cycles=%0d ip=%h ram10=%h retired=%0d", cyc, ip, ram[8'h10], retired);
  endtask

  task automatic test_busy_latency();
    int cyc;
    busy_left = 3;
    lat_next = 2;
    hold_err = 0;
    wr_q.push_back('{a: 8'h11, d: 8'h0F});
    ip_q.push_back(8'h02);
    run_one(1'b0, cyc);
    checks++;
    if (cyc !== 14) begin failures++; $display("FAIL busy_cycles got=%0d required=14", cyc); end
    checks++;
    if (value1 !== 8'd20) begin failures++; $display("FAIL busy_value1 got=%0d required=20", value1); end
    checks++;
    if (value2 !== 8'd5) begin failures++; $display("FAIL busy_value2 got=%0d required=5", value2); end
    checks++;
    if (hold_err !== 0) begin failures++; $display("FAIL rd_en_hold got=%0d drops required=0", hold_err); end
    $display("busy_latency: cycles=%0d value1=%0d value2=%0d", cyc, value1, value2);
  endtask

  task automatic test_branch();
    int cyc;
    br_flag = 1'b1;
    ip_q.push_back(8'h05);
    run_one(1'b0, cyc);
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL branch_cycles got=%0d required=9", cyc); end
    checks++;
    if (ip !== 8'h05) begin failures++; $display("FAIL branch_taken got=%h required=05", ip); end
    $display("branch taken: cycles=%0d ip=%h", cyc, ip);
    br_flag = 1'b0;
    ip_q.push_back(8'h06);
    run_one(1'b0, cyc);
    checks++;
    if (ip !== 8'h06) begin failures++; $display("FAIL branch_not_taken got=%h required=06", ip); end
    $display("branch not taken: ip=%h", ip);
  endtask

  task automatic test_wrap();
    int cyc;
    br_flag = 1'b1;
    ip_q.push_back(8'hFF);
    run_one(1'b0, cyc);
    br_flag = 1'b0;
    wr_q.push_back('{a: 8'h20, d: 8'h07});
    ip_q.push_back(8'h00);
    run_one(1'b0, cyc);
    checks++;
    if (ip !== 8'h00) begin failures++; $display("FAIL ip_wrap got=%h required=00", ip); end
    $display("wrap: ip=%h retired=%0d", ip, retired);
  endtask

  task automatic test_step();
    int cyc;
    wr_q.push_back('{a: 8'h10, d: 8'h07});
    ip_q.push_back(8'h01);
    run_one(1'b1, cyc);
    repeat (25) @(negedge clk);
    checks++;
    if (ip !== 8'h01) begin failures++; $display("FAIL step_ip got=%h required=01", ip); end
    checks++;
    if (retired !== 16'(exp_ret)) begin failures++; $display("FAIL step_retired got=%0d required=%0d", retired, exp_ret); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL step_idle got busy=%b required=0", busy); end
    $display("step: ip=%h retired=%0d busy=%b", ip, retired, busy);
  endtask

  task automatic test_reset_mid();
    int rd_seen, guard;
    rd_seen = 0;
    guard = 0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    while (!(rd_seen == 2 && !ram_rd_en) && guard < 50) begin
      if (ram_rd_en) rd_seen++;
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 50) begin failures++; $display("FAIL reach_wt2 got timeout required WT2"); end
    rstn = 1'b0;
    run = 1'b0;
    exp_ret = 0;
    #1;
    checks++;
    if (ip !== 8'h00) begin failures++; $display("FAIL rst_mid_ip got=%h required=00", ip); end
    checks++;
    if ({busy, ram_rd_en, ram_wr_en} !== 3'b000) begin failures++; $display("FAIL rst_mid_en got=%b required=000", {busy, ram_rd_en, ram_wr_en}); end
    checks++;
    if (value1 !== 8'h00) begin failures++; $display("FAIL rst_mid_value1 got=%h required=00", value1); end
    checks++;
    if (retired !== 16'h0000) begin failures++; $display("FAIL rst_mid_retired got=%h required=0000", retired); end
    checks++;
    if ({alu_op, data_wr, addr_rd} !== 23'h0) begin failures++; $display("FAIL rst_mid_regs got=%h required=0", {alu_op, data_wr, addr_rd}); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    $display("reset mid WT2: ip=%h value1=%h retired=%0d", ip, value1, retired);
  endtask

  task automatic test_halt();
    int cyc, f0;
    wr_q.push_back('{a: 8'h10, d: 8'h07});
    ip_q.push_back(8'h01);
    run_one(1'b1, cyc);
    lmem[1] = {8'h08, 8'h30, 8'h01, 8'h02};
    imem[8] = 7'h7F;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({halted, busy} !== 2'b10) begin failures++; $display("FAIL halt_flags got=%b required=10", {halted, busy}); end
    checks++;
    if (ip !== 8'h01) begin failures++; $display("FAIL halt_ip got=%h required=01", ip); end
    checks++;
    if (retired !== 16'(exp_ret)) begin failures++; $display("FAIL halt_retired got=%0d required=%0d", retired, exp_ret); end
    f0 = fetch_cnt;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
    end
    run = 1'b0;
    checks++;
    if (fetch_cnt !== f0 || halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_sticky got fetches=%0d halted=%b required fetches=%0d halted=1", fetch_cnt, halted, f0);
    end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({halted, ip} !== 9'h000) begin failures++; $display("FAIL halt_exit got halted=%b ip=%h required 0/00", halted, ip); end
    $display("halt: halted after reset=%b ip=%h", halted, ip);
  endtask

  task automatic test_saturate();
    int n, guard;
    n = 0;
    guard = 0;
    sat_run = 1'b1;
    while (n < 6 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (s_ipu) begin
        n++;
        @(negedge clk);
        if (n == 2) begin
          checks++;
          if (s_retired !== 2'd2) begin failures++; $display("FAIL sat_count2 got=%0d required=2", s_retired); end
        end
      end
    end
    sat_run = 1'b0;
    checks++;
    if (s_retired !== 2'd3 || n != 6) begin
      failures++;
      $display("FAIL sat_hold got=%0d after %0d instrs required=3 after 6", s_retired, n);
    end
    $display("saturate: retired=%0d after %0d instructions", s_retired, n);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      lmem[i] = 32'h0;
      imem[i] = 7'h00;
      ram[i]  = 8'h00;
    end
    lmem[0]    = {8'h00, 8'h10, 8'h01, 8'h02};
    imem[0]    = 7'h01;
    lmem[1]    = {8'h01, 8'h11, 8'h03, 8'h04};
    imem[1]    = 7'h02;
    lmem[2]    = {8'h02, 8'h05, 8'h00, 8'h00};
    imem[2]    = 7'h40;
    lmem[5]    = {8'h05, 8'h09, 8'h00, 8'h00};
    imem[5]    = 7'h40;
    lmem[6]    = {8'h06, 8'hFF, 8'h00, 8'h00};
    imem[6]    = 7'h40;
    lmem[8'hFF] = {8'h07, 8'h20, 8'h01, 8'h02};
    imem[7]    = 7'h01;
    ram[1] = 8'd3;
    ram[2] = 8'd4;
    ram[3] = 8'd20;
    ram[4] = 8'd5;

    test_reset();
    test_add();
    test_busy_latency();
    test_branch();
    test_wrap();
    test_step();
    test_reset_mid();
    test_halt();
    test_saturate();

    checks++;
    if (wr_q.size() != 0 || ip_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got writes=%0d ips=%0d left required 0", wr_q.size(), ip_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_core.md
# exec_core

Parametrised execution core that replaces the externally sequenced core with an internal state machine. It fetches a line, looks up the opcode, reads two RAM operands through a busy/valid handshake, drives the ALU, writes the result back (non-control opcodes), and advances or branches the instruction pointer. It adds run/step control, a halt opcode, and a retired-instruction counter. It sits between line memory, instruction memory, RAM and the ALU.

## Interface
Parameters:
- DATA_WIDTH, 8, operand/result width
- BUS_WIDTH, 8, RAM address and line field width; line width = 4*BUS_WIDTH
- IP_WIDTH, 8, instruction pointer width
- OPCODE_WIDTH, 7, opcode width; MSB set = control opcode
- CNT_WIDTH, 16, retired counter width

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- run  in  1  level: execute continuously
- step  in  1  pulse: execute one instruction from IDLE
- line_mem_en  out  1  line read request; line valid next cycle
- ip  out  IP_WIDTH  line address
- line  in  4*BUS_WIDTH  {instr_idx, dest, src1, src2}, MSB first
- instr_mem_en  out  1  opcode read request; opcode valid next cycle
- instr_addr  out  BUS_WIDTH  = latched instr_idx
- opcode  in  OPCODE_WIDTH  opcode from instruction memory
- ram_rd_en, ram_wr_en  out  1  RAM requests, held until accepted
- ram_busy  in  1  request accepted only in a cycle where it is 0
- ram_rd_valid  in  1  data_rd valid (1+ cycles after accept)
- data_rd  in  DATA_WIDTH  read data
- addr_rd, addr_wr  out  BUS_WIDTH  RAM addresses
- data_wr  out  DATA_WIDTH  latched ALU result
- alu_op  out  OPCODE_WIDTH  latched opcode
- value1, value2  out  DATA_WIDTH  latched operands
- result  in  DATA_WIDTH  combinational ALU result
- update_ip  in  1  ALU branch-taken flag
- alu_en  out  1  high in EXEC
- ip_update_en  out  1  high in NEXT
- halted  out  1  sticky halt flag
- busy  out  1  state ≠ IDLE and ≠ HALT
- retired  out  CNT_WIDTH  retired instruction count, saturating

## Operation
- States: IDLE, FETCH, DECODE, OPC, RD1, WT1, RD2, WT2, EXEC, WB, NEXT, HALT.
- IDLE: go to FETCH if run=1 or step=1; otherwise stay.
- FETCH: line_mem_en=1 → DECODE.
- DECODE: latch line into line_q; instr_mem_en=1 → OPC.
- OPC: latch opcode_q. If opcode is all ones, go to HALT; otherwise go to RD1.
- RD1: addr_rd=src1, ram_rd_en=1 until ram_busy=0 → WT1. WT1: on ram_rd_valid latch value1 → RD2.
- RD2/WT2: same as RD1/WT1 with src2; latch value2 → EXEC.
- EXEC: alu_en=1; latch data_wr=result; take_br = opcode_q[MSB] & update_ip. Control opcode → NEXT; otherwise → WB.
- WB: addr_wr=dest, ram_wr_en=1 until ram_busy=0 → NEXT.
- NEXT: ip_update_en=1; ip ← take_br ? dest (zero-extended or truncated to IP_WIDTH) : ip+1 mod 2^IP_WIDTH; retired increments and saturates at all ones. Then → FETCH if run=1, else → IDLE.
- HALT: halted=1, all enables 0, ip unchanged, not retired; leave only by reset.
- run/step are sampled only in IDLE and NEXT. run dropping mid-instruction completes that instruction.
- ram_rd_valid outside WT1/WT2 is ignored. ram_busy is ignored while no request is pending.

## Timing
- Reset: state=IDLE; ip, value1, value2, data_wr, addr_rd, addr_wr, alu_op, retired = 0; all enables, halted, busy = 0. Reset mid-handshake drops the request immediately.
- All outputs are registered or decoded from state only; there are no input-to-output combinational paths except within the ALU.
- Zero-wait RAM (busy=0, valid 1 cycle after accept): 10 cycles for a non-control instruction, 9 for a control instruction, FETCH to FETCH.
- Each busy cycle adds 1 to the RD or WB phase. Each extra valid-latency cycle adds 1 to the WT phase.

## Structure
- The shared params package holds the width defaults, the exec_state_e enum, the line field offsets, and the HALT_OPCODE constant (all ones).
- One sub-module is natural: ram_req_port, the hold-until-accepted request/valid tracker, instantiated once for reads and once for writes.

## Test plan
- Program line 0 = {i0, 8'h10, 8'h01, 8'h02} with opcode 7'h01 (add), RAM[1]=3, RAM[2]=4, run=1 → RAM[0x10]=7, ip=1 after 10 cycles, retired=1.
- ram_busy held high 3 cycles during RD1, read latency 2 → value1 correct; instruction takes 10+3+1 cycles; ram_rd_en held steady throughout.
- Control opcode 7'h40 with update_ip=1, dest=8'h05 → no ram_wr_en, ip=5. With update_ip=0 → ip+1.
- ip=8'hFF, non-branch instruction → ip wraps to 0. retired preset near max → saturates at 16'hFFFF.
- Opcode 7'h7F → HALT: halted=1, busy=0, ip unchanged, retired unchanged; run/step ignored until rstn pulse.
- run=0 with a step pulse → exactly one instruction, then IDLE. rstn asserted during WT2 → all outputs at reset values on the same edge.
